// File: rtl/gpio_access_ctrl_if.sv
// Requester and peripheral-bus signal bundle for gpio_access_ctrl.
// slave: view of the access controller; master: view of requesters plus peripheral model.
interface gpio_access_ctrl_if #(
  parameter int unsigned DW = 8
);
  // Requester side
  logic          req0;
  logic          req1;
  logic          wr0;
  logic          wr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata;
  // Peripheral side
  logic          per_w_en;
  logic          per_r_en;
  logic          per_add;
  logic [DW-1:0] per_data_o;
  logic          per_data_oe;
  logic [DW-1:0] per_data_i;

  modport slave (
    input  req0, req1, wr0, wr1, wdata0, wdata1, per_data_i,
    output gnt0, gnt1, done0, done1, rdata,
    output per_w_en, per_r_en, per_add, per_data_o, per_data_oe
  );

  modport master (
    output req0, req1, wr0, wr1, wdata0, wdata1, per_data_i,
    input  gnt0, gnt1, done0, done1, rdata,
    input  per_w_en, per_r_en, per_add, per_data_o, per_data_oe
  );
endinterface

// File: rtl/gpio_access_ctrl.sv
// Arbiter/sequencer in front of one GPIO peripheral port. Two requesters share the port; each
// granted transfer runs a fixed strobe/address sequence and ends with a one-cycle done pulse.
// Optional feature: define GPIO_ACCESS_CTRL_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise requester 0 has fixed priority.
module gpio_access_ctrl #(
  parameter int unsigned DW       = 8,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned CW       = 4
) (
  input logic               clk,
  input logic               reset,
  gpio_access_ctrl_if.slave bus
);

  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("gpio_access_ctrl: HOLD_CYC=%0d outside 1..15", HOLD_CYC);
  end
  if ((2 ** CW) <= HOLD_CYC) begin : g_bad_cw
    $error("gpio_access_ctrl: CW=%0d too narrow for HOLD_CYC=%0d", CW, HOLD_CYC);
  end

  typedef enum logic [2:0] {
    StIdle, StWrLoad, StWrDrive, StRdCapt, StRdXfer, StEnd
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          owner_sel;
  logic          wr_sel;
`ifdef GPIO_ACCESS_CTRL_RR_EN
  logic          last_q, last_d;
`endif

  // Registered outputs, decoded from the next state so they line up with state_q.
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          w_en_q, w_en_d, r_en_q, r_en_d, add_q, add_d, oe_q, oe_d;
  logic [DW-1:0] data_o_q, data_o_d;

  // Next-state, arbitration and output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef GPIO_ACCESS_CTRL_RR_EN
    last_d    = last_q;
    owner_sel = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
`else
    owner_sel = ~bus.req0;
`endif
    wr_sel = owner_sel ? bus.wr1 : bus.wr0;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          owner_d = owner_sel;
          wdata_d = owner_sel ? bus.wdata1 : bus.wdata0;
          state_d = wr_sel ? StWrLoad : StRdCapt;
        end
      end
      StWrLoad: begin
        cnt_d   = CW'(HOLD_CYC - 1);
        state_d = StWrDrive;
      end
      StWrDrive: begin
        if (cnt_q == '0) state_d = StEnd;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StRdCapt: state_d = StRdXfer;
      StRdXfer: begin
        rdata_d = bus.per_data_i;
        state_d = StEnd;
      end
      StEnd: begin
`ifdef GPIO_ACCESS_CTRL_RR_EN
        last_d = owner_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    w_en_d   = (state_d == StWrLoad) || (state_d == StWrDrive);
    add_d    = (state_d == StWrDrive);
    r_en_d   = (state_d == StRdCapt) || (state_d == StRdXfer);
    oe_d     = w_en_d;
    data_o_d = w_en_d ? wdata_d : '0;
    gnt0_d   = (state_d != StIdle) && !owner_d;
    gnt1_d   = (state_d != StIdle) && owner_d;
    done0_d  = (state_d == StEnd) && !owner_d;
    done1_d  = (state_d == StEnd) && owner_d;
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
`ifdef GPIO_ACCESS_CTRL_RR_EN
      last_q   <= 1'b1;
`endif
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      w_en_q   <= 1'b0;
      r_en_q   <= 1'b0;
      add_q    <= 1'b0;
      oe_q     <= 1'b0;
      data_o_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
`ifdef GPIO_ACCESS_CTRL_RR_EN
      last_q   <= last_d;
`endif
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      w_en_q   <= w_en_d;
      r_en_q   <= r_en_d;
      add_q    <= add_d;
      oe_q     <= oe_d;
      data_o_q <= data_o_d;
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.rdata       = rdata_q;
  assign bus.per_w_en    = w_en_q;
  assign bus.per_r_en    = r_en_q;
  assign bus.per_add     = add_q;
  assign bus.per_data_o  = data_o_q;
  assign bus.per_data_oe = oe_q;

endmodule

// File: tb/tb_gpio_access_ctrl.sv
// Directed bench for gpio_access_ctrl (HOLD_CYC=2). Control vector layout:
// {gnt0, gnt1, done0, done1, w_en, r_en, add, oe}.
module tb_gpio_access_ctrl;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   got [4];
  int   n;
  logic done0_prev = 1'b0;
  logic done1_prev = 1'b0;

  gpio_access_ctrl_if #(.DW(8)) bus ();

  gpio_access_ctrl #(.DW(8), .HOLD_CYC(2), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {bus.gnt0, bus.gnt1, bus.done0, bus.done1,
            bus.per_w_en, bus.per_r_en, bus.per_add, bus.per_data_oe};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Invariants checked every cycle.
  always @(negedge clk) begin
    checks++;
    assert ((bus.per_w_en & bus.per_r_en) === 1'b0) else begin
      errors++; $error("FAIL inv_wen_ren: got 1 expected 0");
    end
    checks++;
    assert ((bus.per_data_oe & bus.per_r_en) === 1'b0) else begin
      errors++; $error("FAIL inv_oe_ren: got 1 expected 0");
    end
    checks++;
    assert ((bus.gnt0 & bus.gnt1) === 1'b0) else begin
      errors++; $error("FAIL inv_gnt_both: got 1 expected 0");
    end
    checks++;
    assert (((bus.done0 & done0_prev) | (bus.done1 & done1_prev)) === 1'b0) else begin
      errors++; $error("FAIL inv_done_width: got 2+ cycle pulse expected 1");
    end
    done0_prev = bus.done0;
    done1_prev = bus.done1;
  end

  initial begin
    reset = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00; bus.per_data_i = 8'h00;
    step(); step();
    chk("rst_ctl", ctl(), 8'h00);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_data_o", bus.per_data_o, 8'h00);
    reset = 1'b1;
    step();
    chk("idle_ctl", ctl(), 8'h00);

    // Abort a write in WR_DRIVE with reset.
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.wdata0 = 8'h77;
    step();
    chk("abort_load", ctl(), 8'b1000_1001);
    step();
    chk("abort_drive", ctl(), 8'b1000_1011);
    reset = 1'b0;
    #1;
    chk("abort_ctl", ctl(), 8'h00);
    chk("abort_data_o", bus.per_data_o, 8'h00);
    bus.req0 = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", ctl(), 8'h00);
    end

    // Write A5 from requester 0.
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.wdata0 = 8'hA5;
    step();
    chk("wr_c1_ctl", ctl(), 8'b1000_1001);
    chk("wr_c1_data", bus.per_data_o, 8'hA5);
    step();
    chk("wr_c2_ctl", ctl(), 8'b1000_1011);
    chk("wr_c2_data", bus.per_data_o, 8'hA5);
    step();
    chk("wr_c3_ctl", ctl(), 8'b1000_1011);
    chk("wr_c3_data", bus.per_data_o, 8'hA5);
    step();
    chk("wr_c4_done", ctl(), 8'b1010_0000);
    chk("wr_rdata", bus.rdata, 8'h00);
    bus.req0 = 1'b0;
    step();
    chk("wr_idle", ctl(), 8'h00);

    // Read from requester 0, pins show 5A.
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.per_data_i = 8'h5A;
    step();
    chk("rd0_c1_ctl", ctl(), 8'b1000_0100);
    chk("rd0_c1_rdata", bus.rdata, 8'h00);
    step();
    chk("rd0_c2_ctl", ctl(), 8'b1000_0100);
    chk("rd0_c2_rdata", bus.rdata, 8'h00);
    step();
    chk("rd0_c3_done", ctl(), 8'b1010_0000);
    chk("rd0_c3_rdata", bus.rdata, 8'h5A);
    bus.req0 = 1'b0;
    step();
    chk("rd0_idle_rdata", bus.rdata, 8'h5A);

    // Read from requester 1, 3C valid during RD_XFER.
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.per_data_i = 8'hFF;
    step();
    chk("rd1_c1_ctl", ctl(), 8'b0100_0100);
    bus.per_data_i = 8'h3C;
    step();
    chk("rd1_c2_ctl", ctl(), 8'b0100_0100);
    step();
    chk("rd1_c3_done", ctl(), 8'b0101_0000);
    chk("rd1_c3_rdata", bus.rdata, 8'h3C);
    bus.req1 = 1'b0; bus.per_data_i = 8'h00;
    step();
    chk("rd1_idle", ctl(), 8'h00);

    // Write 11 from requester 1; rdata must hold 3C.
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.wdata1 = 8'h11;
    step();
    chk("wr1_c1_ctl", ctl(), 8'b0100_1001);
    step();
    chk("wr1_c2_data", bus.per_data_o, 8'h11);
    step();
    step();
    chk("wr1_c4_done", ctl(), 8'b0101_0000);
    chk("wr1_rdata_hold", bus.rdata, 8'h3C);
    bus.req1 = 1'b0;
    step();

    // Simultaneous reads from a fresh reset.
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.req1 = 1'b1; bus.wr1 = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (bus.done0) begin got[n] = 0; n++; end
      else if (bus.done1) begin got[n] = 1; n++; end
    end
    chk("arb_count", n, 4);
    for (int k = 0; k < n; k++) begin
`ifdef GPIO_ACCESS_CTRL_RR_EN
      chk("arb_order", got[k], k % 2);
`else
      chk("arb_order", got[k], 0);
`endif
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step(); step();
    chk("final_idle", ctl(), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
